// File: rtl/seg_msg_animator_if.sv
// Message-write and display-pin bundle for seg_msg_animator.
// The controller/board side uses master; the animator itself uses slave.
interface seg_msg_animator_if #(
    parameter int N_DIGITS  = 8,
    parameter int MSG_DEPTH = 16
);
    localparam int AW = $clog2(MSG_DEPTH);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [4:0]          wr_char;
    logic [AW:0]         msg_len;
    logic [1:0]          mode;
    logic [6:0]          segmentos;
    logic [N_DIGITS-1:0] anodos;
    logic                frame_start;
    logic                wrap;

    modport master (output wr_en, wr_addr, wr_char, msg_len, mode,
                    input  segmentos, anodos, frame_start, wrap);
    modport slave  (input  wr_en, wr_addr, wr_char, msg_len, mode,
                    output segmentos, anodos, frame_start, wrap);
endinterface

// File: rtl/seg_msg_animator.sv
// N-digit multiplexed 7-segment message driver with static, scroll, blink and
// freeze modes; all pin outputs are registered and reflect the previous cycle's scan state.
module seg_msg_animator #(
    parameter int N_DIGITS    = 8,
    parameter int MSG_DEPTH   = 16,
    parameter int REFRESH_DIV = 12500,
    parameter int STEP_DIV    = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_msg_animator_if.slave bus
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int DW = $clog2(N_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_SCROLL = 2'b01,
        M_BLINK  = 2'b10,
        M_FREEZE = 2'b11
    } mode_e;

    logic [4:0]          msg_q [MSG_DEPTH];
    logic [RW-1:0]       slot_q;
    logic [DW-1:0]       dig_q;
    logic [SW-1:0]       step_q;
    logic [AW-1:0]       rd_idx_q, rd_idx_d, offset_q, offset_d, off_a;
    logic [AW:0]         len_q, len_n, off_inc, rd_inc;
    mode_e               mode_q, mode_n;
    logic                blink_q, blink_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_q, wrap_q, wrap_d;
    logic                frame, slot_end, step_tick, lit;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: glyph = 7'b0000001;
            5'h01: glyph = 7'b1001111;
            5'h02: glyph = 7'b0010010;
            5'h03: glyph = 7'b0000110;
            5'h04: glyph = 7'b1001100;
            5'h05: glyph = 7'b0100100;
            5'h06: glyph = 7'b0100000;
            5'h07: glyph = 7'b0001111;
            5'h08: glyph = 7'b0000000;
            5'h09: glyph = 7'b0000100;
            5'h0A: glyph = 7'b0001000;
            5'h0B: glyph = 7'b1100000;
            5'h0C: glyph = 7'b0110001;
            5'h0D: glyph = 7'b1000010;
            5'h0E: glyph = 7'b0110000;
            5'h0F: glyph = 7'b0111000;
            5'h10: glyph = 7'b1001000;
            5'h11: glyph = 7'b1110001;
            5'h12: glyph = 7'b0011000;
            5'h13: glyph = 7'b1000001;
            5'h14: glyph = 7'b1111110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign slot_end  = (slot_q == RW'(REFRESH_DIV - 1));
    assign frame     = (slot_q == '0) && (dig_q == DW'(N_DIGITS - 1));
    assign step_tick = (step_q == SW'(STEP_DIV - 1));

    always_comb begin
        len_n  = frame ? bus.msg_len : len_q;
        mode_n = frame ? mode_e'(bus.mode) : mode_q;

        // Frame boundary: static/blink restart at 0, and a shrunk message never leaves offset past its end.
        off_a = offset_q;
        if (frame && ((mode_n == M_STATIC) || (mode_n == M_BLINK) || ({1'b0, offset_q} >= len_n)))
            off_a = '0;

        off_inc  = {1'b0, off_a} + ONE;
        offset_d = off_a;
        wrap_d   = 1'b0;
        if (step_tick && (mode_n == M_SCROLL) && (len_n != '0)) begin
            offset_d = (off_inc == len_n) ? '0 : off_inc[AW-1:0];
            wrap_d   = (off_inc == len_n);
        end

        rd_inc   = {1'b0, rd_idx_q} + ONE;
        rd_idx_d = rd_idx_q;
        if (frame)
            rd_idx_d = off_a;
        else if (slot_end)
            rd_idx_d = ((rd_inc == len_q) || (len_q == '0)) ? '0 : rd_inc[AW-1:0];

        blink_d = (mode_n == M_BLINK) ? (blink_q ^ step_tick) : 1'b1;

        lit   = (slot_q != '0) && blink_q && (len_q != '0);
        an_d  = lit ? ~(N_DIGITS'(1) << dig_q) : '1;
        seg_d = lit ? glyph(msg_q[rd_idx_q]) : 7'b1111111;
    end

    // Buffer is deliberately outside reset; a zero length keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (bus.wr_en)
            msg_q[bus.wr_addr] <= bus.wr_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            dig_q    <= '0;
            step_q   <= '0;
            rd_idx_q <= '0;
            offset_q <= '0;
            len_q    <= '0;
            mode_q   <= M_STATIC;
            blink_q  <= 1'b1;
            seg_q    <= 7'b1111111;
            an_q     <= '1;
            frame_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            if (slot_end) begin
                slot_q <= '0;
                dig_q  <= (dig_q == '0) ? DW'(N_DIGITS - 1) : dig_q - DW'(1);
            end else begin
                slot_q <= slot_q + RW'(1);
            end
            step_q   <= step_tick ? '0 : step_q + SW'(1);
            rd_idx_q <= rd_idx_d;
            offset_q <= offset_d;
            len_q    <= len_n;
            mode_q   <= mode_n;
            blink_q  <= blink_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.segmentos   = seg_q;
    assign bus.anodos      = an_q;
    assign bus.frame_start = frame_q;
    assign bus.wrap        = wrap_q;
endmodule

// File: tb/tb_seg_msg_animator.sv
// Directed bench for seg_msg_animator: expected digit glyphs are queued when
// stimulus is applied and popped as each scanned frame is observed.
module tb_seg_msg_animator;
    localparam int N  = 4;
    localparam int DP = 16;
    localparam int R  = 4;
    localparam int S  = 40;
    localparam int AW = $clog2(DP);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_msg_animator_if #(.N_DIGITS(N), .MSG_DEPTH(DP)) bus ();

    seg_msg_animator #(.N_DIGITS(N), .MSG_DEPTH(DP), .REFRESH_DIV(R), .STEP_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wrap_cyc[$];
    logic [6:0] exp_q[$];
    logic [4:0] mbuf[DP];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.wrap === 1'b1) wrap_cyc.push_back(cyc);

    function automatic logic [6:0] gl(input logic [4:0] c);
        case (c)
            5'h00: gl = 7'b0000001;
            5'h01: gl = 7'b1001111;
            5'h05: gl = 7'b0100100;
            5'h06: gl = 7'b0100000;
            5'h0A: gl = 7'b0001000;
            5'h10: gl = 7'b1001000;
            5'h14: gl = 7'b1111110;
            default: gl = 7'b1111111;
        endcase
    endfunction

    function automatic int dec(input logic [6:0] s, input int len);
        dec = -1;
        for (int i = 0; i < len; i++) if (dec < 0 && gl(mbuf[i]) == s) dec = i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: DUT event did not occur in time", tag);
    endtask

    task automatic wr(input int a, input logic [4:0] c);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_char = c; mbuf[a] = c;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic push_msg(input int off, input int len);
        for (int i = 0; i < N; i++) exp_q.push_back(gl(mbuf[(off + i) % len]));
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.frame_start !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) fail({tag, "_frame_timeout"});
    endtask

    // Leaves the caller on the dead cycle that starts the following frame.
    task automatic sample_frame(input string tag, output logic [N-1:0][6:0] g,
                                input bit do_wr, input int wa, input logic [4:0] wc);
        logic [N-1:0] oh;
        g = '1;
        wait_frame(tag);
        for (int d = N - 1; d >= 0; d--) begin
            chk({tag, "_dead_an"}, bus.anodos, {N{1'b1}});
            @(negedge clk);
            oh = ~(N'(1) << d);
            chk({tag, "_an"}, bus.anodos, oh);
            g[d] = bus.segmentos;
            if (do_wr && d == N - 1) begin
                bus.wr_en = 1'b1; bus.wr_addr = AW'(wa); bus.wr_char = wc;
            end
            for (int k = 1; k < R; k++) begin @(negedge clk); bus.wr_en = 1'b0; end
        end
    endtask

    task automatic check_frame(input string tag, input bit do_wr, input int wa, input logic [4:0] wc);
        logic [N-1:0][6:0] g;
        logic [6:0] e;
        sample_frame(tag, g, do_wr, wa, wc);
        for (int d = N - 1; d >= 0; d--) begin
            if (exp_q.size() == 0) fail({tag, "_queue_empty"});
            else begin
                e = exp_q.pop_front();
                chk({tag, "_seg"}, g[d], e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, o, prev, lc, i, j;
        int fs[$];
        int rs[$];
        int re[$];
        bit dk[$];
        bit found;
        logic [N-1:0][6:0] g;
        logic [N-1:0] oh;
        logic [27:0] ev;
        logic [5:0] seen;

        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_char = '0; bus.msg_len = '0; bus.mode = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_anodos", bus.anodos, 4'hF);
        chk("rst_seg", bus.segmentos, 7'h7F);
        chk("rst_frame", bus.frame_start, 1'b0);
        chk("rst_wrap", bus.wrap, 1'b0);
        rst = 1'b0;

        // Zero length: permanently blank, frames still tick every N*R cycles.
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.anodos !== 4'hF || bus.segmentos !== 7'h7F) bad++;
            if (bus.frame_start === 1'b1) fs.push_back(cyc);
        end
        chk("len0_blank", bad, 0);
        chk("len0_frame_count", (fs.size() == 12 || fs.size() == 13), 1'b1);
        if (fs.size() >= 2) chk("len0_frame_period", fs[1] - fs[0], N * R);
        else fail("len0_frame_period");

        wr(0, 5'h0A); wr(1, 5'h01); wr(2, 5'h00); wr(3, 5'h14);
        bus.msg_len = 5'd4; bus.mode = 2'b00;
        push_msg(0, 4);
        check_frame("static", 1'b0, 0, '0);

        // Scroll over six characters.
        wr(4, 5'h05); wr(5, 5'h06);
        bus.msg_len = 5'd6; bus.mode = 2'b01;
        i = wrap_cyc.size(); j = 0;
        while (wrap_cyc.size() == i && j < 600) begin @(negedge clk); j++; end
        if (j >= 600) fail("scroll_first_wrap");
        prev = 0; seen = '0;
        for (int f = 0; f < 20; f++) begin
            sample_frame("scroll", g, 1'b0, 0, '0);
            o = dec(g[N-1], 6);
            if (f == 0) chk("scroll_first_off", o, 0);
            else chk("scroll_step", (o == prev || o == (prev + 1) % 6), 1'b1);
            if (o >= 0) begin
                seen[o] = 1'b1;
                for (int d = 0; d < N; d++) ev[d*7 +: 7] = gl(mbuf[(o + N - 1 - d) % 6]);
                chk("scroll_digits", g, ev);
                prev = o;
            end
        end
        chk("scroll_all_offsets", seen, 6'h3F);
        if (wrap_cyc.size() >= 2)
            chk("wrap_period", wrap_cyc[wrap_cyc.size()-1] - wrap_cyc[wrap_cyc.size()-2], 6 * S);
        else fail("wrap_period");

        // Blink: record a window and split it into off runs and lit phases.
        bus.mode = 2'b10;
        wait_frame("blink");
        bad = 0;
        for (int k = 0; k < 280; k++) begin
            dk.push_back(bus.anodos === 4'hF);
            if (bus.anodos !== 4'hF) begin
                found = 1'b0;
                for (int d = 0; d < N; d++) begin
                    oh = ~(N'(1) << d);
                    if (bus.anodos === oh) begin
                        found = 1'b1;
                        if (bus.segmentos !== gl(mbuf[N - 1 - d])) bad++;
                    end
                end
                if (!found) bad++;
            end else if (bus.segmentos !== 7'h7F) bad++;
            @(negedge clk);
        end
        chk("blink_lit_pattern", bad, 0);
        i = 0;
        while (i < dk.size()) begin
            if (dk[i]) begin
                j = i;
                while (j < dk.size() && dk[j]) j++;
                if (j - i >= 2 && i > 0 && j < dk.size()) begin rs.push_back(i); re.push_back(j); end
                i = j;
            end else i++;
        end
        chk("blink_off_runs", rs.size() >= 3, 1'b1);
        if (rs.size() >= 3) begin
            for (int k = 0; k < 2; k++) begin
                chk("blink_off_len", (re[k] - rs[k] == S || re[k] - rs[k] == S + 1), 1'b1);
                lc = 0;
                for (int m = re[k]; m < rs[k+1]; m++) if (!dk[m]) lc++;
                chk("blink_on_lit", lc, S - S / R);
            end
        end

        // Shrinking the message while scrolled far right restarts at buf[0].
        bus.mode = 2'b01; bus.msg_len = 5'd6;
        found = 1'b0;
        for (int f = 0; f < 24 && !found; f++) begin
            sample_frame("find5", g, 1'b0, 0, '0);
            if (dec(g[N-1], 6) == 5) found = 1'b1;
        end
        if (!found) fail("find_offset5");
        bus.msg_len = 5'd3;
        push_msg(0, 3);
        check_frame("len_clamp", 1'b0, 0, '0);

        bus.mode = 2'b00;
        mbuf[1] = 5'h10;
        push_msg(0, 3);
        check_frame("midframe_wr", 1'b1, 1, 5'h10);

        // Reset while digit 2 is lit, after scrolling away from offset 0.
        bus.mode = 2'b01; bus.msg_len = 5'd6;
        found = 1'b0;
        for (int f = 0; f < 24 && !found; f++) begin
            sample_frame("find_off", g, 1'b0, 0, '0);
            o = dec(g[N-1], 6);
            if (o >= 1 && o <= 3) found = 1'b1;
        end
        if (!found) fail("find_nonzero_offset");
        wait_frame("rst_wait");
        repeat (5) @(negedge clk);
        chk("an2_active", bus.anodos, 4'b1011);
        rst = 1'b1; bus.mode = 2'b11;
        @(negedge clk);
        chk("midrst_anodos", bus.anodos, 4'hF);
        chk("midrst_seg", bus.segmentos, 7'h7F);
        chk("midrst_frame", bus.frame_start, 1'b0);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.anodos !== 4'hF || bus.segmentos !== 7'h7F) bad++;
        end
        chk("midrst_len0", bad, 0);
        push_msg(0, 6);
        check_frame("post_rst_freeze", 1'b0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
